alu_share_arbiter: RTL and testbench

- Shares one registered 32-bit ALU (4-bit opcode, one-cycle registered result) between two requesters.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU operand and opcode inputs for exactly one cycle.
- Waits the ALU latency, then returns the captured result on a per-requester valid/ready response channel.
- Sits between the decode/issue logic of two pipelines or masters and the shared ALU instance.

---
 rtl/alu_share_arbiter_if.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester channels and the shared-ALU connection used by alu_share_arbiter.
// slave = arbiter side, master = requesters and ALU side.
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [3:0]        req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              resp0_valid;
   logic              resp0_ready;
   logic [DATA_W-1:0] resp0_result;
   logic              resp0_err;

   logic              req1_valid;
   logic              req1_ready;
   logic [3:0]        req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              resp1_valid;
   logic              resp1_ready;
   logic [DATA_W-1:0] resp1_result;
   logic              resp1_err;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] alu_result;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, resp0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, resp1_ready,
      input  alu_result,
      output req0_ready, resp0_valid, resp0_result, resp0_err,
      output req1_ready, resp1_valid, resp1_result, resp1_err,
      output alu_a, alu_b, alu_op
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, resp0_ready,
      output req1_valid, req1_op, req1_a, req1_b, resp1_ready,
      output alu_result,
      input  req0_ready, resp0_valid, resp0_result, resp0_err,
      input  req1_ready, resp1_valid, resp1_result, resp1_err,
      input  alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between two requesters: arbitrate, issue for one cycle, wait ALU_LAT, respond.
// Optional macro ALU_SHARE_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin pointer).
module alu_share_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ALU_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   alu_share_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd9);
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;
   logic [2:0]        r_wait_cnt;
   logic [3:0]        r_alu_op;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [1:0]        r_resp_valid;
   logic [1:0]        r_resp_err;
   logic [DATA_W-1:0] r_resp_result0;
   logic [DATA_W-1:0] r_resp_result1;
`ifndef ALU_SHARE_FIXED_PRIO_EN
   logic              r_ptr;
`endif

   logic              w_grant0;
   logic              w_grant1;
   logic              w_hs;
   logic [3:0]        w_sel_op;
   logic [DATA_W-1:0] w_sel_a;
   logic [DATA_W-1:0] w_sel_b;
   logic              w_sel_legal;
   logic              w_wait_done;
   logic              w_resp_fire;

   // Grant to the winning valid requester; grants only exist while idle.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (r_state == S_IDLE) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
         w_grant0 = bus.req0_valid;
         w_grant1 = bus.req1_valid & ~bus.req0_valid;
`else
         if (bus.req0_valid && bus.req1_valid) begin
            w_grant0 = ~r_ptr;
            w_grant1 = r_ptr;
         end else begin
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid;
         end
`endif
      end else begin
         w_grant0 = 1'b0;
         w_grant1 = 1'b0;
      end
   end

   assign w_hs        = w_grant0 | w_grant1;
   assign w_sel_op    = w_grant1 ? bus.req1_op : bus.req0_op;
   assign w_sel_a     = w_grant1 ? bus.req1_a  : bus.req0_a;
   assign w_sel_b     = w_grant1 ? bus.req1_b  : bus.req0_b;
   assign w_sel_legal = op_legal(w_sel_op);
   assign w_wait_done = (r_wait_cnt == 3'd0);
   assign w_resp_fire = (r_state == S_RESP) && (r_owner ? bus.resp1_ready : bus.resp0_ready);

   // Next-state logic; rejected opcodes bypass the ALU and go straight to RESP.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               w_state_nxt = w_sel_legal ? S_ISSUE : S_RESP;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (w_wait_done) begin
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_RESP: begin
            if (w_resp_fire) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RESP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Owner latch and ALU-latency countdown (loaded in ISSUE, counts through WAIT).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= 1'b0;
         r_wait_cnt <= 3'd0;
      end else begin
         if (w_hs) begin
            r_owner <= w_grant1;
         end
         if (r_state == S_ISSUE) begin
            r_wait_cnt <= 3'(ALU_LAT - 1);
         end else if ((r_state == S_WAIT) && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
         end
      end
   end

   // ALU drive: operands are latched at handshake, opcode is nonzero only during ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_op <= 4'b0000;
         r_alu_a  <= {DATA_W{1'b0}};
         r_alu_b  <= {DATA_W{1'b0}};
      end else begin
         r_alu_op <= (w_hs && w_sel_legal) ? w_sel_op : 4'b0000;
         if (w_hs && w_sel_legal) begin
            r_alu_a <= w_sel_a;
            r_alu_b <= w_sel_b;
         end
      end
   end

   // Response channels; only the owner's channel is ever raised.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_valid   <= 2'b00;
         r_resp_err     <= 2'b00;
         r_resp_result0 <= {DATA_W{1'b0}};
         r_resp_result1 <= {DATA_W{1'b0}};
      end else if (w_resp_fire) begin
         r_resp_valid <= 2'b00;
         r_resp_err   <= 2'b00;
      end else if (w_hs && !w_sel_legal) begin
         r_resp_valid <= w_grant1 ? 2'b10 : 2'b01;
         r_resp_err   <= w_grant1 ? 2'b10 : 2'b01;
         if (w_grant1) begin
            r_resp_result1 <= {DATA_W{1'b0}};
         end else begin
            r_resp_result0 <= {DATA_W{1'b0}};
         end
      end else if ((r_state == S_WAIT) && w_wait_done) begin
         r_resp_valid <= r_owner ? 2'b10 : 2'b01;
         r_resp_err   <= 2'b00;
         if (r_owner) begin
            r_resp_result1 <= bus.alu_result;
         end else begin
            r_resp_result0 <= bus.alu_result;
         end
      end
   end

`ifndef ALU_SHARE_FIXED_PRIO_EN
   // Round-robin pointer moves to the non-owner on every completed response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (w_resp_fire) begin
         r_ptr <= ~r_owner;
      end
   end
`endif

   assign bus.req0_ready   = w_grant0;
   assign bus.req1_ready   = w_grant1;
   assign bus.resp0_valid  = r_resp_valid[0];
   assign bus.resp1_valid  = r_resp_valid[1];
   assign bus.resp0_err    = r_resp_err[0];
   assign bus.resp1_err    = r_resp_err[1];
   assign bus.resp0_result = r_resp_result0;
   assign bus.resp1_result = r_resp_result1;
   assign bus.alu_op       = r_alu_op;
   assign bus.alu_a        = r_alu_a;
   assign bus.alu_b        = r_alu_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a bench-side ALU and a transaction-timeline reference model.
module tb_alu_share_arbiter;
   localparam int DW  = 32;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;

   alu_share_arbiter_if #(.DATA_W(DW)) bus ();

   alu_share_arbiter #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] prev);
      case (op)
         4'd1: return a + b;
         4'd2: return a - b;
         4'd3: return a * b;
         4'd4: return a & b;
         4'd5: return a | b;
         4'd6: return a ^ b;
         4'd7: return ~(a | b);
         4'd8: return (a + b) << 3;
         4'd9: return prev << 3;
         default: return prev;
      endcase
   endfunction

   // Bench-side shared ALU: one-cycle registered result, holds when op is zero.
   logic [31:0] alu_out = 32'd0;
   always @(posedge clk) if (bus.alu_op != 4'd0) alu_out <= alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, alu_out);
   assign bus.alu_result = alu_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: tracks the one outstanding transaction as a timeline.
   logic        chk_en = 1'b0;
   logic        m_pend = 1'b0, m_owner = 1'b0, m_legal = 1'b0, m_errv = 1'b0, m_ptr = 1'b0;
   logic [3:0]  m_op = 4'd0;
   int          m_issue = -1, m_rstart = 0;
   logic [31:0] m_val = 32'd0, m_prev = 32'd0, m_a = 32'd0, m_b = 32'd0;
   logic [31:0] m_res0 = 32'd0, m_res1 = 32'd0;

   always @(negedge clk) begin : model
      logic e_r0, e_r1, e_v0, e_v1, inresp, pr;
      logic [3:0] e_op, op;
      logic [31:0] a, b;
      inresp = m_pend && (cyc >= m_rstart);
`ifdef ALU_SHARE_FIXED_PRIO_EN
      pr = 1'b0;
`else
      pr = m_ptr;
`endif
      e_r0 = !m_pend && bus.req0_valid && (!bus.req1_valid || !pr);
      e_r1 = !m_pend && bus.req1_valid && (!bus.req0_valid || pr);
      e_op = (m_pend && m_legal && (cyc == m_issue)) ? m_op : 4'd0;
      e_v0 = inresp && !m_owner;
      e_v1 = inresp && m_owner;
      if (chk_en) begin
         check("m_req0_ready", bus.req0_ready, e_r0);
         check("m_req1_ready", bus.req1_ready, e_r1);
         check("m_alu_op", bus.alu_op, e_op);
         check("m_alu_a", bus.alu_a, m_a);
         check("m_alu_b", bus.alu_b, m_b);
         check("m_resp0_valid", bus.resp0_valid, e_v0);
         check("m_resp1_valid", bus.resp1_valid, e_v1);
         check("m_resp0_err", bus.resp0_err, e_v0 && m_errv);
         check("m_resp1_err", bus.resp1_err, e_v1 && m_errv);
         check("m_resp0_result", bus.resp0_result, m_res0);
         check("m_resp1_result", bus.resp1_result, m_res1);
      end
      if (rst) begin
         chk_en = 1'b1; m_pend = 1'b0; m_ptr = 1'b0; m_a = 32'd0; m_b = 32'd0;
         m_res0 = 32'd0; m_res1 = 32'd0;
      end else begin
         if (inresp && (m_owner ? bus.resp1_ready : bus.resp0_ready)) begin
            m_pend = 1'b0;
            m_ptr  = !m_owner;
         end else if (e_r0 || e_r1) begin
            op = e_r1 ? bus.req1_op : bus.req0_op;
            a  = e_r1 ? bus.req1_a  : bus.req0_a;
            b  = e_r1 ? bus.req1_b  : bus.req0_b;
            m_pend = 1'b1; m_owner = e_r1; m_op = op;
            m_legal = (op >= 4'd1) && (op <= 4'd9);
            if (m_legal) begin
               m_val = alu_ref(op, a, b, m_prev); m_prev = m_val;
               m_a = a; m_b = b; m_errv = 1'b0;
               m_issue = cyc + 1; m_rstart = cyc + 2 + LAT;
            end else begin
               m_val = 32'd0; m_errv = 1'b1; m_issue = -1; m_rstart = cyc + 1;
            end
         end
         if (m_pend && (cyc + 1 == m_rstart)) begin
            if (m_owner) m_res1 = m_val; else m_res0 = m_val;
         end
      end
   end

   task automatic set_req(input int n, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   task automatic do_req(input int n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int t_hs);
      logic got = 1'b0;
      t_hs = -1;
      set_req(n, 1'b1, op, a, b);
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin got = 1'b1; t_hs = cyc; end
      end
      if (!got) check("req_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      set_req(n, 1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic wait_resp(input int n, input logic [31:0] exp, input logic err,
                            input string name, output int t_r);
      logic got = 1'b0;
      t_r = -1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if ((n == 0) ? bus.resp0_valid : bus.resp1_valid) begin
            got = 1'b1; t_r = cyc;
            check({name, "_result"}, (n == 0) ? bus.resp0_result : bus.resp1_result, exp);
            check({name, "_err"}, (n == 0) ? bus.resp0_err : bus.resp1_err, err);
         end
      end
      if (!got) check({name, "_timeout"}, 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic check_zero(input string name);
      check({name, "_rdy"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
      check({name, "_vld"}, {bus.resp0_valid, bus.resp1_valid}, 2'b00);
      check({name, "_err"}, {bus.resp0_err, bus.resp1_err}, 2'b00);
      check({name, "_res"}, {bus.resp0_result, bus.resp1_result}, 64'd0);
      check({name, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
      check({name, "_alu_op"}, bus.alu_op, 4'd0);
   endtask

   initial begin
      int t_hs, t_r, t0, t1, t_c, tx, ty;
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;

      // Single add: issue at T+1, response at T+3.
      do_req(0, 4'd1, 32'd5, 32'd7, t_hs);
      @(negedge clk);
      check("add_issue_op", bus.alu_op, 4'd1);
      wait_resp(0, 32'd12, 1'b0, "add", t_r);
      check("add_latency", t_r - t_hs, 3);

      // Contention right after a requester-0 completion.
      fork
         begin do_req(0, 4'd5, 32'd3, 32'd12, tx); wait_resp(0, 32'd15, 1'b0, "cont_r0", t0); end
         begin do_req(1, 4'd6, 32'hFF, 32'h0F, ty); wait_resp(1, 32'hF0, 1'b0, "cont_r1", t1); end
      join
`ifdef ALU_SHARE_FIXED_PRIO_EN
      check("cont_order", t0 < t1, 1'b1);
`else
      check("cont_order", t1 < t0, 1'b1);
`endif

      // Both valid after reset: requester 0 first.
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      fork
         begin do_req(0, 4'd2, 32'd10, 32'd3, tx); wait_resp(0, 32'd7, 1'b0, "both_r0", t0); end
         begin do_req(1, 4'd3, 32'd4, 32'd6, ty); wait_resp(1, 32'd24, 1'b0, "both_r1", t1); end
      join
      check("both_order", t0 < t1, 1'b1);

      // Response backpressure with requester 0 waiting.
      bus.resp1_ready = 1'b0;
      do_req(1, 4'd4, 32'hF0F0, 32'h0FF0, t_hs);
      set_req(0, 1'b1, 4'd1, 32'd1, 32'd1);
      t_c = 0;
      for (int i = 0; i < 20 && t_c == 0; i++) begin
         @(negedge clk);
         if (bus.resp1_valid) t_c = 1;
      end
      check("bp_seen", t_c, 1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("bp_hold_valid", bus.resp1_valid, 1'b1);
         check("bp_hold_result", bus.resp1_result, 32'h00F0);
         check("bp_r0_blocked", bus.req0_ready, 1'b0);
      end
      @(posedge clk); #1 bus.resp1_ready = 1'b1;
      @(negedge clk);
      check("bp_last_valid", bus.resp1_valid, 1'b1);
      check("bp_last_result", bus.resp1_result, 32'h00F0);
      t_c = cyc;
      @(negedge clk);
      check("bp_r0_ready_next", bus.req0_ready, 1'b1);
      check("bp_r0_ready_cycle", cyc - t_c, 1);
      @(posedge clk); #1 set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      wait_resp(0, 32'd2, 1'b0, "bp_r0", t_r);

      // Illegal opcode: error response one cycle after the handshake.
      do_req(0, 4'hC, 32'd9, 32'd9, t_hs);
      wait_resp(0, 32'd0, 1'b1, "illegal", t_r);
      check("illegal_latency", t_r - t_hs, 1);

      // Shift consumes the previous ALU output.
      do_req(0, 4'd8, 32'd1, 32'd6, t_hs);
      wait_resp(0, 32'd56, 1'b0, "shift_r0", t_r);
      do_req(1, 4'd9, 32'd0, 32'd0, t_hs);
      wait_resp(1, 32'd448, 1'b0, "shift_r1", t_r);

      // Reset during WAIT abandons the operation.
      do_req(0, 4'd1, 32'd2, 32'd3, t_hs);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_zero("rst_wait");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_resp", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
      end
      @(posedge clk); #1;
      do_req(1, 4'd6, 32'hFF, 32'h0F, t_hs);
      wait_resp(1, 32'hF0, 1'b0, "post_rst", t_r);
      check("post_rst_latency", t_r - t_hs, 3);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
